// File: rtl/line_window_buffer.sv
// ============================================================================
// line_window_buffer
//
// Streaming line buffer feeding a vertical pixel window to an edge-detection
// kernel. The last P_ROWS image lines live in a circular row store. Every
// accepted pixel produces one vertical column of P_ROWS pixels: the pixels at
// the same column index in the older lines, oldest first, followed by the
// incoming pixel itself. The first P_ROWS-1 lines of each frame are only stored
// ("priming") and produce no column.
//
// Ports
//   I_CLK           clock, all logic on the rising edge
//   I_RESET_N       synchronous active-low reset (takes priority over I_ENABLE)
//   I_ENABLE        global enable; low freezes the block completely
//   I_PIXEL         incoming pixel
//   I_PIXEL_VALID   I_PIXEL is valid
//   I_SOF           start of frame, qualified by I_PIXEL_VALID
//   O_PIXEL_READY   block can accept a pixel this cycle (combinational)
//   O_COLUMN        column; slice k = [k*D +: D], k=0 oldest line,
//                   k=P_ROWS-1 the current pixel
//   O_COLUMN_VALID  O_COLUMN / O_COL / O_ROW are valid
//   I_COLUMN_READY  downstream takes the column
//   O_COL           column index of the current pixel
//   O_ROW           image row index of the current pixel
// ============================================================================
module line_window_buffer #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 8
) (
    input  logic                              I_CLK,
    input  logic                              I_RESET_N,
    input  logic                              I_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0]          I_PIXEL,
    input  logic                              I_PIXEL_VALID,
    input  logic                              I_SOF,
    output logic                              O_PIXEL_READY,
    output logic [P_ROWS*P_PIXEL_DEPTH-1:0]   O_COLUMN,
    output logic                              O_COLUMN_VALID,
    input  logic                              I_COLUMN_READY,
    output logic [$clog2(P_COLUMNS)-1:0]      O_COL,
    output logic [15:0]                       O_ROW
);

    localparam int COL_W = $clog2(P_COLUMNS);
    localparam int PTR_W = $clog2(P_ROWS);
    localparam int D     = P_PIXEL_DEPTH;

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(P_COLUMNS - 1);
    localparam logic [PTR_W-1:0] LAST_LINE = PTR_W'(P_ROWS - 1);

    // Circular row store; never reset, the fill counter keeps stale lines out
    // of any emitted column.
    logic [D-1:0] row_store [P_ROWS][P_COLUMNS];

    logic [COL_W-1:0]          col_count;
    logic [PTR_W-1:0]          line_ptr;
    logic [PTR_W-1:0]          fill_count;
    logic [15:0]               row_count;

    logic                      pixel_ready;
    logic                      accept;
    logic [COL_W-1:0]          eff_col;
    logic [PTR_W-1:0]          eff_ptr;
    logic [PTR_W-1:0]          eff_fill;
    logic [15:0]               eff_row;
    logic                      last_col;
    logic [P_ROWS*D-1:0]       next_column;

    // Physical line holding window slice k, given the line currently written.
    // Slice k sits (P_ROWS-1-k) lines behind the write pointer, which modulo
    // P_ROWS is the same as (ptr + k + 1).
    function automatic logic [PTR_W-1:0] line_index(input logic [PTR_W-1:0] ptr,
                                                    input int k);
        int idx;
        idx = (int'(ptr) + k + 1) % P_ROWS;
        return PTR_W'(idx);
    endfunction

    // The ready path deliberately ignores I_PIXEL_VALID so upstream can use it
    // without a combinational loop.
    assign pixel_ready   = I_ENABLE & (~O_COLUMN_VALID | I_COLUMN_READY);
    assign O_PIXEL_READY = pixel_ready;
    assign accept        = I_PIXEL_VALID & pixel_ready;

    // A start-of-frame pixel is treated as column 0 of line 0 of an empty
    // store, so the position/fill seen by this pixel is overridden here.
    always_comb begin
        eff_col  = col_count;
        eff_ptr  = line_ptr;
        eff_fill = fill_count;
        eff_row  = row_count;
        if (I_SOF) begin
            eff_col  = '0;
            eff_ptr  = '0;
            eff_fill = '0;
            eff_row  = '0;
        end
    end

    assign last_col = (eff_col == LAST_COL);

    // Assemble the column from the older lines (read before the pixel is
    // written) with the incoming pixel on top.
    always_comb begin
        next_column = '0;
        for (int k = 0; k < P_ROWS - 1; k++) begin
            next_column[k*D +: D] = row_store[line_index(eff_ptr, k)][eff_col];
        end
        next_column[(P_ROWS-1)*D +: D] = I_PIXEL;
    end

    // Row store write port.
    always_ff @(posedge I_CLK) begin
        if (I_RESET_N && accept) begin
            row_store[eff_ptr][eff_col] <= I_PIXEL;
        end
    end

    // Position counters. At the end of a line the ring pointer moves on, the
    // fill level climbs until the window is primed, and the row count advances.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            col_count  <= '0;
            line_ptr   <= '0;
            fill_count <= '0;
            row_count  <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_count  <= '0;
                line_ptr   <= (eff_ptr == LAST_LINE) ? '0 : eff_ptr + 1'b1;
                fill_count <= (eff_fill == LAST_LINE) ? eff_fill : eff_fill + 1'b1;
                row_count  <= eff_row + 16'd1;
            end else begin
                col_count  <= eff_col + 1'b1;
                line_ptr   <= eff_ptr;
                fill_count <= eff_fill;
                row_count  <= eff_row;
            end
        end
    end

    // Output register. Accept is only possible when the current column is
    // being taken (or none is pending), so loading on accept never loses data
    // and gives one column per clock. With I_ENABLE low nothing moves.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            O_COLUMN       <= '0;
            O_COL          <= '0;
            O_ROW          <= '0;
            O_COLUMN_VALID <= 1'b0;
        end else if (accept) begin
            O_COLUMN       <= next_column;
            O_COL          <= eff_col;
            O_ROW          <= eff_row;
            O_COLUMN_VALID <= (eff_fill == LAST_LINE);
        end else if (I_ENABLE && O_COLUMN_VALID && I_COLUMN_READY) begin
            O_COLUMN_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// ============================================================================
// tb_line_window_buffer
//
// Scoreboard bench for line_window_buffer (4 columns, 3 rows, 8-bit pixels).
// The driver keeps a picture of the current frame indexed by (row, col) and,
// for every accepted pixel from the third frame line on, queues the expected
// vertical window. A monitor pops and compares on every column transfer.
// ============================================================================
module tb_line_window_buffer;

    localparam int C = 4;
    localparam int R = 3;
    localparam int D = 8;

    logic              I_CLK = 1'b0;
    logic              I_RESET_N;
    logic              I_ENABLE;
    logic [D-1:0]      I_PIXEL;
    logic              I_PIXEL_VALID;
    logic              I_SOF;
    logic              O_PIXEL_READY;
    logic [R*D-1:0]    O_COLUMN;
    logic              O_COLUMN_VALID;
    logic              I_COLUMN_READY;
    logic [1:0]        O_COL;
    logic [15:0]       O_ROW;

    line_window_buffer #(
        .P_COLUMNS     (C),
        .P_ROWS        (R),
        .P_PIXEL_DEPTH (D)
    ) dut (
        .I_CLK          (I_CLK),
        .I_RESET_N      (I_RESET_N),
        .I_ENABLE       (I_ENABLE),
        .I_PIXEL        (I_PIXEL),
        .I_PIXEL_VALID  (I_PIXEL_VALID),
        .I_SOF          (I_SOF),
        .O_PIXEL_READY  (O_PIXEL_READY),
        .O_COLUMN       (O_COLUMN),
        .O_COLUMN_VALID (O_COLUMN_VALID),
        .I_COLUMN_READY (I_COLUMN_READY),
        .O_COL          (O_COL),
        .O_ROW          (O_ROW)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic [R*D-1:0] column;
        logic [1:0]     col;
        logic [15:0]    row;
        int             cyc;
    } want_t;

    want_t       sb[$];
    logic [D-1:0] img [int];
    int          m_row = 0;
    int          m_col = 0;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int stall        = 0;
    int freeze       = 0;
    bit rand_bp      = 0;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        n_compared++;
        if (act !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Frame-level reference: place the pixel in the picture; once two earlier
    // lines exist, the window is the same column of the two lines above.
    task automatic modelAccept(input logic [D-1:0] p, input logic s, input int stamp);
        want_t w;
        if (s) begin
            m_row = 0;
            m_col = 0;
            img.delete();
        end
        img[m_row*C + m_col] = p;
        if (m_row >= R - 1) begin
            for (int k = 0; k < R; k++) begin
                w.column[k*D +: D] = img[(m_row - (R - 1 - k))*C + m_col];
            end
            w.col = 2'(m_col);
            w.row = 16'(m_row);
            w.cyc = stamp;
            sb.push_back(w);
        end
        m_col++;
        if (m_col == C) begin
            m_col = 0;
            m_row = (m_row + 1) % 65536;
        end
    endtask

    // One clock of driving; reports whether the pixel was taken.
    task automatic driveCycle(input logic v, input logic [D-1:0] p, input logic s, output logic acc);
        int stamp;
        I_PIXEL_VALID = v;
        I_PIXEL       = p;
        I_SOF         = s;
        if (stall > 0) begin
            I_COLUMN_READY = 1'b0;
            stall--;
        end else begin
            I_COLUMN_READY = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (freeze > 0) begin
            I_ENABLE = 1'b0;
            freeze--;
        end else begin
            I_ENABLE = 1'b1;
        end
        @(negedge I_CLK);
        acc   = v & O_PIXEL_READY & I_RESET_N;
        stamp = cyc;
        @(posedge I_CLK);
        if (acc) modelAccept(p, s, stamp);
        #1;
    endtask

    task automatic applyStimulus(input logic [D-1:0] p, input logic s);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            driveCycle(1'b1, p, s, acc);
        end
        if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
        I_PIXEL_VALID = 1'b0;
        I_SOF         = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int t = 0; t < n; t++) driveCycle(1'b0, 8'h00, 1'b0, acc);
    endtask

    // Reset for one edge while pixel traffic is offered, then check the
    // cleared outputs before releasing it.
    task automatic resetDut(input logic en);
        I_RESET_N      = 1'b0;
        I_ENABLE       = en;
        I_PIXEL_VALID  = 1'b1;
        I_PIXEL        = 8'hA5;
        I_SOF          = 1'b0;
        I_COLUMN_READY = 1'b1;
        sb.delete();
        img.delete();
        m_row = 0;
        m_col = 0;
        @(posedge I_CLK);
        #1;
        I_PIXEL_VALID = 1'b0;
        checkOutput("reset_valid",  64'(O_COLUMN_VALID), 64'd0);
        checkOutput("reset_column", 64'(O_COLUMN), 64'd0);
        checkOutput("reset_col",    64'(O_COL), 64'd0);
        checkOutput("reset_row",    64'(O_ROW), 64'd0);
        checkOutput("reset_ready",  64'(O_PIXEL_READY), 64'(en));
        I_RESET_N = 1'b1;
        I_ENABLE  = 1'b1;
    endtask

    // Monitor: ready equation, hold under stall/freeze, one-cycle latency,
    // and scoreboard comparison on each transfer.
    bit              have_prev = 0;
    bit              prev_hold = 0;
    logic [63:0]     prev_snap;

    always @(negedge I_CLK) begin
        if (!I_RESET_N) begin
            have_prev = 0;
        end else begin
            checkOutput("pixel_ready", 64'(O_PIXEL_READY),
                        64'(I_ENABLE & (~O_COLUMN_VALID | I_COLUMN_READY)));
            if (have_prev && prev_hold) begin
                checkOutput("hold", {21'd0, O_COLUMN_VALID, O_COLUMN, O_COL, O_ROW}, prev_snap);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                checkOutput("latency_valid", 64'(O_COLUMN_VALID), 64'd1);
            end
            if (O_COLUMN_VALID && I_COLUMN_READY && I_ENABLE) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_column", 64'(O_COLUMN), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    want_t w;
                    w = sb.pop_front();
                    checkOutput("column", 64'(O_COLUMN), 64'(w.column));
                    checkOutput("col",    64'(O_COL),    64'(w.col));
                    checkOutput("row",    64'(O_ROW),    64'(w.row));
                end
            end
            prev_hold = O_COLUMN_VALID && !(I_COLUMN_READY && I_ENABLE);
            prev_snap = {21'd0, O_COLUMN_VALID, O_COLUMN, O_COL, O_ROW};
            have_prev = 1;
        end
    end

    initial begin
        int px;
        I_RESET_N      = 1'b0;
        I_ENABLE       = 1'b1;
        I_PIXEL        = '0;
        I_PIXEL_VALID  = 1'b0;
        I_SOF          = 1'b0;
        I_COLUMN_READY = 1'b1;
        repeat (2) @(posedge I_CLK);
        #1;

        resetDut(1'b0);
        resetDut(1'b1);

        // Priming and first windows, then ring pointer wrap over six lines.
        applyStimulus(8'd1, 1'b1);
        for (int i = 2; i <= 24; i++) applyStimulus(8'(i), 1'b0);

        // Downstream stall for three cycles while a column is pending.
        stall = 3;
        for (int i = 25; i <= 28; i++) applyStimulus(8'(i), 1'b0);

        // New frame starting mid-line at column 2.
        applyStimulus(8'd29, 1'b0);
        applyStimulus(8'd30, 1'b0);
        applyStimulus(8'd31, 1'b1);
        for (int i = 32; i <= 44; i++) applyStimulus(8'(i), 1'b0);

        // Freeze for four cycles mid-line.
        applyStimulus(8'd45, 1'b0);
        freeze = 4;
        for (int i = 46; i <= 52; i++) applyStimulus(8'(i), 1'b0);
        idle(3);

        // Reset in the middle of a frame, then a frame without SOF.
        for (int i = 53; i <= 58; i++) applyStimulus(8'(i), 1'b0);
        resetDut(1'b1);
        for (int i = 59; i <= 74; i++) applyStimulus(8'(i), 1'b0);

        // Randomized traffic with backpressure, freezes, gaps and SOFs.
        rand_bp = 1;
        for (int n = 0; n < 400; n++) begin
            px = int'($urandom_range(0, 255));
            if ($urandom_range(0, 29) == 0) freeze = int'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 2)));
            applyStimulus(8'(px), ($urandom_range(0, 49) == 0));
        end

        rand_bp = 0;
        stall   = 0;
        freeze  = 0;
        idle(6);
        checkOutput("drain_pending", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
